mini_alu_exec: RTL

//  Parametrised execute stage for the MiniAlu processor family. It takes a decoded operation and two register operands,
//  and returns a registered result plus write-enable, branch decision and status flags. Multiplies are iterative

---
 rtl/mini_alu_exec.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mini_alu_exec.sv
// mini_alu_exec: execute stage for the MiniAlu processor family.
// Single-cycle ALU, branch and store ops; iterative shift-add multiply that
// stalls the front end through oReady while it runs. Results, write enable,
// branch decision and flags are registered and qualified by a one-cycle oValid.
// oResult for BLE, JMP, NOP and illegal opcodes is zero; the branch target is
// resolved upstream, so only the taken/not-taken decision is produced here.
// Shifts move iSrc1 by the amount held in the low bits of iSrc0.
module mini_alu_exec #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int BLE_SIGNED = 0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic [3:0]            iOperation,
    input  logic [DATA_W-1:0]     iSrc0,
    input  logic [DATA_W-1:0]     iSrc1,
    input  logic [DATA_W-1:0]     iImmediate,
    input  logic [ADDR_W-1:0]     iDestination,
    output logic                  oValid,
    output logic                  oWriteEnable,
    output logic [ADDR_W-1:0]     oDestination,
    output logic [2*DATA_W-1:0]   oResult,
    output logic                  oBranchTaken,
    output logic [3:0]            oFlags,
    output logic                  oIllegal
);

    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_UMUL = 4'h8;
    localparam logic [3:0] OP_SMUL = 4'h9;
    localparam logic [3:0] OP_BLE  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_STO  = 4'hC;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(DATA_W - 1);

    // State and datapath registers
    logic [1:0]            state_reg;
    logic [SH_W-1:0]       cnt_reg;
    logic [2*DATA_W-1:0]   mcand_reg;
    logic [DATA_W-1:0]     mplier_reg;
    logic [2*DATA_W-1:0]   acc_reg;
    logic                  neg_reg;
    logic [ADDR_W-1:0]     dest_reg;
    logic [2*DATA_W-1:0]   result_reg;
    logic [3:0]            flags_reg;
    logic                  valid_reg;
    logic                  we_reg;
    logic                  br_reg;
    logic                  ill_reg;

    // Single-cycle datapath results
    logic [DATA_W:0]       sum_ext;
    logic [DATA_W:0]       diff_ext;
    logic                  ble_take;
    logic [DATA_W-1:0]     alu_res;
    logic                  alu_c;
    logic                  alu_v;
    logic                  alu_we;
    logic                  alu_br;
    logic                  alu_ill;
    logic                  alu_keep;
    logic                  alu_mul;
    logic                  smul_sel;
    logic [DATA_W-1:0]     mag0;
    logic [DATA_W-1:0]     mag1;

    // Multiply step
    logic [2*DATA_W-1:0]   acc_next;
    logic [2*DATA_W-1:0]   mul_prod;

    assign sum_ext  = {1'b0, iSrc0} + {1'b0, iSrc1};
    assign diff_ext = {1'b0, iSrc1} - {1'b0, iSrc0};

    generate
        if (BLE_SIGNED != 0) begin : g_ble_signed
            assign ble_take = $signed(iSrc1) <= $signed(iSrc0);
        end else begin : g_ble_unsigned
            assign ble_take = iSrc1 <= iSrc0;
        end
    endgenerate

    // Signed multiply works on magnitudes; the negation of the most-negative
    // value wraps to itself, which is the correct unsigned magnitude.
    assign smul_sel = (iOperation == OP_SMUL);
    assign mag0     = (smul_sel && iSrc0[MSB]) ? (~iSrc0 + 1'b1) : iSrc0;
    assign mag1     = (smul_sel && iSrc1[MSB]) ? (~iSrc1 + 1'b1) : iSrc1;

    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign mul_prod = neg_reg ? (~acc_next + 1'b1) : acc_next;

    // Opcode decode for everything that completes in one cycle
    always_comb begin
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        alu_we   = 1'b0;
        alu_br   = 1'b0;
        alu_ill  = 1'b0;
        alu_keep = 1'b0;
        alu_mul  = 1'b0;
        case (iOperation)
            OP_NOP: alu_keep = 1'b1;
            OP_ADD: begin
                alu_res = sum_ext[DATA_W-1:0];
                alu_c   = sum_ext[DATA_W];
                alu_v   = (iSrc0[MSB] == iSrc1[MSB]) && (sum_ext[MSB] != iSrc0[MSB]);
                alu_we  = 1'b1;
            end
            OP_SUB: begin
                alu_res = diff_ext[DATA_W-1:0];
                alu_c   = diff_ext[DATA_W];
                alu_v   = (iSrc1[MSB] != iSrc0[MSB]) && (diff_ext[MSB] != iSrc1[MSB]);
                alu_we  = 1'b1;
            end
            OP_AND: begin alu_res = iSrc0 & iSrc1; alu_we = 1'b1; end
            OP_OR:  begin alu_res = iSrc0 | iSrc1; alu_we = 1'b1; end
            OP_XOR: begin alu_res = iSrc0 ^ iSrc1; alu_we = 1'b1; end
            OP_SHL: begin alu_res = iSrc1 << iSrc0[SH_W-1:0]; alu_we = 1'b1; end
            OP_SHR: begin alu_res = iSrc1 >> iSrc0[SH_W-1:0]; alu_we = 1'b1; end
            OP_UMUL, OP_SMUL: alu_mul = 1'b1;
            OP_BLE: alu_br = ble_take;
            OP_JMP: alu_br = 1'b1;
            OP_STO: begin alu_res = iImmediate; alu_we = 1'b1; end
            default: begin
                alu_ill  = 1'b1;
                alu_keep = 1'b1;
            end
        endcase
    end

    // Control FSM, output registers and shift-add multiplier
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            neg_reg    <= 1'b0;
            dest_reg   <= '0;
            result_reg <= '0;
            flags_reg  <= '0;
            valid_reg  <= 1'b0;
            we_reg     <= 1'b0;
            br_reg     <= 1'b0;
            ill_reg    <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            we_reg    <= 1'b0;
            br_reg    <= 1'b0;
            ill_reg   <= 1'b0;
            case (state_reg)
                ST_MUL: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        result_reg <= mul_prod;
                        flags_reg  <= {mul_prod[2*DATA_W-1], mul_prod == '0, 2'b00};
                        valid_reg  <= 1'b1;
                        we_reg     <= 1'b1;
                        state_reg  <= ST_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept; DONE allows back-to-back issue
                    if (iValid) begin
                        dest_reg <= iDestination;
                        if (alu_mul) begin
                            mcand_reg  <= {{DATA_W{1'b0}}, mag0};
                            mplier_reg <= mag1;
                            acc_reg    <= '0;
                            cnt_reg    <= '0;
                            neg_reg    <= smul_sel && (iSrc0[MSB] ^ iSrc1[MSB]);
                            state_reg  <= ST_MUL;
                        end else begin
                            result_reg <= {{DATA_W{1'b0}}, alu_res};
                            valid_reg  <= 1'b1;
                            we_reg     <= alu_we;
                            br_reg     <= alu_br;
                            ill_reg    <= alu_ill;
                            if (!alu_keep) begin
                                flags_reg <= {alu_res[MSB], alu_res == '0, alu_c, alu_v};
                            end
                            state_reg  <= ST_DONE;
                        end
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign oReady       = (state_reg != ST_MUL);
    assign oValid       = valid_reg;
    assign oWriteEnable = we_reg;
    assign oDestination = dest_reg;
    assign oResult      = result_reg;
    assign oBranchTaken = br_reg;
    assign oFlags       = flags_reg;
    assign oIllegal     = ill_reg;

endmodule
